// File: rtl/mini16_vram_write_arbiter.sv
// Round-robin arbiter for the single VRAM write port of mini16_soc.
// The owner keeps the port while it holds req, for up to BURST_MAX accepted
// writes. On release, arbitration restarts at owner+1, so the previous owner is
// scanned last. The accepted word is registered onto vram_we/addr/data one cycle
// after the transfer edge.
module mini16_vram_write_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 3,
  parameter int BURST_MAX  = 8,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = $clog2(BURST_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            grant,
  output logic                        vram_we,
  output logic [ADDR_WIDTH-1:0]       vram_addr,
  output logic [DATA_WIDTH-1:0]       vram_data,
  output logic [IW-1:0]               owner
);

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;

  logic            keep;        // owner continues its burst this cycle
  logic [IW-1:0]   next_owner;  // owner_q + 1 mod N_REQ
  logic [IW-1:0]   scan_start;
  logic            found;       // a requester was picked by the rotation scan
  logic [IW-1:0]   scan_win;
  logic            hit;         // a transfer is offered this cycle
  logic [IW-1:0]   win_sel;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  assign next_owner = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);
  assign owner      = owner_q;

  // Pick the winner: continue the burst, or scan the rotation from the release point.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    keep       = 1'b0;
    scan_start = ptr_q;
    found      = 1'b0;
    scan_win   = '0;
    hit        = 1'b0;
    win_sel    = '0;
    sel_addr   = '0;
    sel_data   = '0;
    grant      = '0;

    if (state_q == S_OWN) begin
      keep       = req[owner_q] && (cnt_q < CW'(BURST_MAX));
      scan_start = next_owner;
    end

    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (int'(scan_start) + k) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        scan_win = IW'(idx);
      end
    end

    hit     = keep || found;
    win_sel = keep ? owner_q : scan_win;

    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == win_sel) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    if (!reset && hit) grant[win_sel] = 1'b1;
  end

  // Ownership state, rotation pointer and registered VRAM write port.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      vram_we <= hit;
      if (hit) begin
        vram_addr <= sel_addr;
        vram_data <= sel_data;
      end

      if (keep) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        if (state_q == S_OWN) ptr_q <= next_owner;
        if (found) begin
          state_q <= S_OWN;
          owner_q <= scan_win;
          cnt_q   <= CW'(1);
        end else begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mini16_vram_write_arbiter.sv
// Self-checking bench for mini16_vram_write_arbiter: directed scenarios plus a
// randomized protocol-obeying traffic phase, all compared against a behavioural
// model of ownership, burst count and rotation pointer kept in plain integers.
module tb_mini16_vram_write_arbiter;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 3;
  localparam int BM = 8;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    grant;
  logic            vram_we;
  logic [AW-1:0]   vram_addr;
  logic [DW-1:0]   vram_data;
  logic [IW-1:0]   owner;

  mini16_vram_write_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .grant(grant), .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
    .owner(owner)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: -1 owner means nobody holds the port.
  int            m_owner = -1;
  int            m_cnt   = 0;
  int            m_ptr   = 0;
  int            m_last  = 0;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;
  logic [N-1:0]  last_xfer = '0;

  // DUT observations per tick, for directed checks against spec constants.
  logic [N-1:0]  g_hist[$];
  logic          we_hist[$];
  logic [AW-1:0] a_hist[$];
  logic [DW-1:0] d_hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  // One clock: compare at negedge, then advance the model across the posedge.
  task automatic tick();
    int           win;
    bit           cont;
    logic [N-1:0] eg;
    @(negedge clk);
    win  = -1;
    cont = 1'b0;
    if (m_owner >= 0 && req[m_owner] && m_cnt < BM) begin
      cont = 1'b1;
      win  = m_owner;
    end else begin
      win = first_from((m_owner >= 0) ? (m_owner + 1) % N : m_ptr);
    end
    eg = '0;
    if (!reset && win >= 0) eg[win] = 1'b1;

    check("grant",     32'(grant),     32'(eg));
    check("vram_we",   32'(vram_we),   32'(m_we));
    check("vram_addr", 32'(vram_addr), 32'(m_addr));
    check("vram_data", 32'(vram_data), 32'(m_data));
    check("owner",     32'(owner),     32'(m_last));
    g_hist.push_back(grant);
    we_hist.push_back(vram_we);
    a_hist.push_back(vram_addr);
    d_hist.push_back(vram_data);

    @(posedge clk);
    if (reset) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0; m_last = 0;
      m_we = 1'b0; m_addr = '0; m_data = '0; last_xfer = '0;
    end else begin
      last_xfer = eg;
      m_we = (win >= 0);
      if (win >= 0) begin
        m_addr = req_addr[win*AW +: AW];
        m_data = req_data[win*DW +: DW];
        m_last = win;
      end
      if (cont) begin
        m_cnt++;
      end else begin
        if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
        if (win >= 0) begin m_owner = win; m_cnt = 1; end
        else          begin m_owner = -1;  m_cnt = 0; end
      end
    end
    #1;
  endtask

  task automatic clear_hist();
    g_hist.delete(); we_hist.delete(); a_hist.delete(); d_hist.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    tick();
    reset = 1'b0;
    clear_hist();
  endtask

  task automatic set_req(input int i, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    int bubbles;
    int k0;
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    req_data = '0;

    // Reset state.
    do_reset();
    check("reset_we",    32'(vram_we),   32'd0);
    check("reset_addr",  32'(vram_addr), 32'd0);
    check("reset_owner", 32'(owner),     32'd0);

    // Single write from requester 0.
    set_req(0, 1'b1, 13'h0010, 3'd5);
    tick();
    req = '0;
    tick();
    tick();
    check("t1_grant", 32'(g_hist[0]),  32'b0001);
    check("t1_we1",   32'(we_hist[1]), 32'd1);
    check("t1_addr",  32'(a_hist[1]),  32'h0010);
    check("t1_data",  32'(d_hist[1]),  32'd5);
    check("t1_we2",   32'(we_hist[2]), 32'd0);
    check("t1_hold",  32'(a_hist[2]),  32'h0010);

    // All four requesting: bursts of 8 in rotation, no bubbles.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(13'h100 * (i + 1)), DW'(i + 1));
    for (int c = 0; c < 40; c++) tick();
    for (int b = 0; b < 5; b++)
      check("t2_order", 32'(g_hist[b*BM]), 32'(1 << (b % N)));
    bubbles = 0;
    for (int c = 1; c < 40; c++) if (!we_hist[c]) bubbles++;
    check("t2_bubbles", 32'(bubbles), 32'd0);

    // req0 held, req2 joins at write 3: owner 0 finishes 8, then 2.
    do_reset();
    req = '0;
    set_req(0, 1'b1, 13'h0aa0, 3'd1);
    tick(); tick();
    set_req(2, 1'b1, 13'h0bb0, 3'd2);
    for (int c = 0; c < 8; c++) tick();
    check("t3_last0", 32'(g_hist[7]), 32'b0001);
    check("t3_to2",   32'(g_hist[8]), 32'b0100);

    // req0 drops after 3 writes with req1 waiting: port moves at once.
    do_reset();
    req = '0;
    set_req(0, 1'b1, 13'h0001, 3'd3);
    set_req(1, 1'b1, 13'h0002, 3'd4);
    tick(); tick(); tick();
    req[0] = 1'b0;
    tick();
    // With ptr=1 after the release, requester 2 beats 0 once 1 lets go.
    req = '0;
    set_req(2, 1'b1, 13'h0003, 3'd5);
    set_req(0, 1'b1, 13'h0004, 3'd6);
    tick();
    check("t4_to1",  32'(g_hist[3]), 32'b0010);
    check("t4_ptr1", 32'(g_hist[4]), 32'b0100);

    // Sole requester 3: regains the port at the burst limit with no gap.
    do_reset();
    req = '0;
    set_req(3, 1'b1, 13'h1fff, 3'd7);
    for (int c = 0; c < 20; c++) tick();
    bubbles = 0;
    for (int c = 0; c < 20; c++) if (g_hist[c] != 4'b1000) bubbles++;
    for (int c = 1; c < 20; c++) if (!we_hist[c]) bubbles++;
    check("t5_continuous", 32'(bubbles), 32'd0);
    check("t5_owner",      32'(owner),   32'd3);

    // Reset mid-burst (cnt=4), then rotation restarts at 0.
    do_reset();
    req = '0;
    set_req(0, 1'b1, 13'h0123, 3'd2);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = '0;
    set_req(1, 1'b1, 13'h0456, 3'd3);
    set_req(2, 1'b1, 13'h0789, 3'd4);
    tick();
    k0 = 4;
    check("t6_grant_rst", 32'(g_hist[k0]),     32'd0);
    check("t6_we_after",  32'(we_hist[k0+1]),  32'd0);
    check("t6_first1",    32'(g_hist[k0+1]),   32'b0010);

    // Randomized traffic: requesters hold addr/data until granted.
    do_reset();
    req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] || last_xfer[i]) begin
          if ($urandom_range(99) < 65)
            set_req(i, 1'b1, AW'($urandom), DW'($urandom));
          else
            req[i] = 1'b0;
        end
      end
      reset = ($urandom_range(199) == 0);
      tick();
    end
    reset = 1'b0;
    req   = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
